obstacle_bus_reader: RTL and testbench
======================================

# obstacle_bus_reader

Game-side receiver for the obstacle generator chip's multiplexed output bus. It drives the obstacle-select line and samples the 12-bit pos/type bus through a synchronizer, once for each obstacle. It then commits both obstacles as one atomic snapshot for the collision and render logic. A capture runs once per frame, started by `frame_start`.

## Interface
Parameters:
- `SETTLE`, default 2: cycles the bus is given to settle after `sel` changes, on top of the 2 synchronizer cycles.
- `MAX_RETRY`, default 4: stability extensions allowed per phase. Used only when the macro is enabled.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `frame_start` in 1: one-cycle request to capture a snapshot.
- `bus_lo` in 8: obstacle pos[7:0], from the generator's dedicated outputs.
- `bus_hi` in 4: {type[2:0], pos[8]}, from generator IO bits [3:0].
- `sel` out 1: registered obstacle select. 1 selects obstacle 1, 0 selects obstacle 2.
- `obs1_pos` out 9, `obs1_type` out 3: committed obstacle 1.
- `obs2_pos` out 9, `obs2_type` out 3: committed obstacle 2.
- `snap_valid` out 1: one-cycle pulse when a new snapshot is committed.
- `busy` out 1: high while a capture is in progress.
- `snap_err` out 1: the last snapshot hit the retry limit. Constant 0 without the macro.

## Operation
- Bus inputs pass through a 2-flop synchronizer. Define `sync = {pos, type}`, decoded as pos = {bus_hi[0], bus_lo}, type = bus_hi[3:1].
- FSM states:
  - IDLE: on `frame_start`, go to PH1.
  - PH1: `sel`=1. Run the wait counter `W = SETTLE+2`. On expiry, store sync into shadow register 1, set `sel`=0 and go to PH2.
  - PH2: same wait. On expiry, store shadow register 2 and go to COMMIT.
  - COMMIT: copy both shadow registers to the `obs*` outputs, pulse `snap_valid`, return to IDLE.
- The `obs*` outputs change only in COMMIT. The two obstacles are never updated separately.
- `frame_start` is ignored while `busy`=1. It is never queued.
- `busy` is 1 in PH1, PH2 and COMMIT.
- Reset values: state IDLE, `sel`=0, every `obs*`=0, `snap_valid`=0, `busy`=0, `snap_err`=0, synchronizer and shadow registers 0.
- Reset mid-capture aborts immediately. No snapshot is committed and outputs return to their reset values.

## Timing
- `frame_start` is sampled high at edge E0. `sel`=1 from E0.
- Capture 1 happens at edge E0+W. `sel`=0 from that edge.
- Capture 2 happens at edge E0+2W.
- Outputs update and `snap_valid` goes high at edge E0+2W+1, for exactly one cycle. `busy` falls at the same edge.
- With SETTLE=2 the snapshot is committed 9 cycles after the `frame_start` edge.
- The earliest accepted new `frame_start` is the cycle in which `snap_valid` is high. It is sampled at edge E0+2W+2.

## Configuration
- `OBSTACLE_READER_STABLE_EN` defined:
  - At each phase expiry, sync must equal its value from the previous cycle.
  - On mismatch, the phase extends by one cycle, up to `MAX_RETRY` times.
  - When the limit is exhausted, the latest sample is taken and an error flag is set for that snapshot.
  - `snap_err` is loaded in COMMIT: 1 if either phase exhausted its retries, otherwise 0.
- Macro undefined:
  - No comparison and no extension. Capture timing is fixed.
  - `snap_err` is tied to 0.

## Structure
- Package `obstacle_pkg` holds:
  - `POS_W`=9, `TYPE_W`=3, `BUS_W`=12.
  - `obstacle_t` struct {pos, type}.
  - FSM state enum {IDLE, PH1, PH2, COMMIT}.
  - The select-polarity constant `SEL_OBS1`=1'b1.
- Sub-module `bus_sync2`: a parameterized-width 2-flop synchronizer with asynchronous reset.

## Test plan
- Reset: with `rst_n` low, every output is 0. After release with no `frame_start`, outputs stay 0 for 50 cycles.
- Basic capture (SETTLE=2):
  - Stimulus: the bus model returns pos=0x1A5, type=3 when `sel`=1 and pos=0x042, type=5 when `sel`=0. Pulse `frame_start`.
  - Required: `snap_valid` 9 cycles later, with obs1=0x1A5/3 and obs2=0x042/5. `sel` sequence is 1 for 4 cycles, then 0.
- Busy rejection: a second `frame_start` at E0+3 produces no second `snap_valid`. A `frame_start` in the `snap_valid` cycle starts a new capture.
- Atomicity: change the bus values mid-PH2. `obs1` holds its old value until COMMIT, then both outputs update on the same edge.
- Reset mid-capture: assert `rst_n` low at E0+5. No `snap_valid` appears, outputs are 0, and the next `frame_start` completes normally.
- STABLE_EN:
  - Toggle pos bit 0 every cycle during PH1. Required: `snap_err`=1 after 4 extensions, commit at E0+13.
  - With a stable bus, `snap_err`=0.

Source files
------------

// File: rtl/obstacle_pkg.sv
// Shared widths, payload struct, FSM encoding and select polarity for the obstacle bus reader.
package obstacle_pkg;

    localparam int unsigned POS_W  = 9;
    localparam int unsigned TYPE_W = 3;
    localparam int unsigned BUS_W  = POS_W + TYPE_W;

    // 'type' is a reserved word, so the obstacle type field is named 'kind'.
    typedef struct packed {
        logic [POS_W-1:0]  pos;
        logic [TYPE_W-1:0] kind;
    } obstacle_t;

    typedef enum logic [1:0] {
        IDLE,
        PH1,
        PH2,
        COMMIT
    } state_t;

    localparam logic SEL_OBS1 = 1'b1;

endpackage

// File: rtl/obstacle_bus_reader_bus_sync2.sv
// Parameterized-width two-flop synchronizer with asynchronous active-low reset.
module bus_sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/obstacle_bus_reader.sv
// Captures both obstacles from the multiplexed generator bus and commits them as one snapshot.
// Optional bus-stability retry checking is enabled by OBSTACLE_READER_STABLE_EN.
module obstacle_bus_reader
    import obstacle_pkg::*;
#(
    parameter int unsigned SETTLE    = 2,
    parameter int unsigned MAX_RETRY = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic [7:0] bus_lo,
    input  logic [3:0] bus_hi,
    output logic       sel,
    output logic [8:0] obs1_pos,
    output logic [2:0] obs1_type,
    output logic [8:0] obs2_pos,
    output logic [2:0] obs2_type,
    output logic       snap_valid,
    output logic       busy,
    output logic       snap_err
);

`ifdef OBSTACLE_READER_STABLE_EN
    localparam bit STABLE_EN = 1'b1;
`else
    localparam bit STABLE_EN = 1'b0;
`endif

    localparam int unsigned WAIT  = SETTLE + 2;
    localparam int unsigned CNT_W = $clog2(WAIT + 1);
    localparam int unsigned RTY_W = $clog2(MAX_RETRY + 2);

    logic [BUS_W-1:0] sync_raw;
    logic [BUS_W-1:0] sync_bits;
    obstacle_t        sync;
    obstacle_t        sync_prev;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RTY_W-1:0] rty_q, rty_d;
    logic             err_q, err_d;
    obstacle_t        shad1_q, shad1_d;
    obstacle_t        shad2_q, shad2_d;
    obstacle_t        obs1_q, obs1_d;
    obstacle_t        obs2_q, obs2_d;
    logic             sel_q, sel_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             serr_q, serr_d;
    logic             expire, unstable, extend;

    // Bus order {pos[8], pos[7:0], type} lines up with obstacle_t packing.
    assign sync_raw = {bus_hi[0], bus_lo, bus_hi[3:1]};

    bus_sync2 #(.WIDTH(BUS_W)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sync_raw),
        .q     (sync_bits)
    );

    assign sync = obstacle_t'(sync_bits);

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rty_q     <= '0;
            err_q     <= 1'b0;
            shad1_q   <= '0;
            shad2_q   <= '0;
            obs1_q    <= '0;
            obs2_q    <= '0;
            sel_q     <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            serr_q    <= 1'b0;
            sync_prev <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rty_q     <= rty_d;
            err_q     <= err_d;
            shad1_q   <= shad1_d;
            shad2_q   <= shad2_d;
            obs1_q    <= obs1_d;
            obs2_q    <= obs2_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            serr_q    <= serr_d;
            sync_prev <= sync;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rty_d    = rty_q;
        err_d    = err_q;
        shad1_d  = shad1_q;
        shad2_d  = shad2_q;
        obs1_d   = obs1_q;
        obs2_d   = obs2_q;
        sel_d    = sel_q;
        busy_d   = busy_q;
        valid_d  = 1'b0;
        serr_d   = serr_q;
        expire   = (cnt_q == CNT_W'(WAIT - 1));
        unstable = STABLE_EN && (sync != sync_prev);
        extend   = unstable && (rty_q != RTY_W'(MAX_RETRY));

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d = PH1;
                    sel_d   = SEL_OBS1;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    rty_d   = '0;
                    err_d   = 1'b0;
                end
            end
            PH1: begin
                if (!expire) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (extend) begin
                    rty_d = rty_q + RTY_W'(1);
                end else begin
                    shad1_d = sync;
                    sel_d   = ~SEL_OBS1;
                    state_d = PH2;
                    cnt_d   = '0;
                    rty_d   = '0;
                    err_d   = err_q | unstable;
                end
            end
            PH2: begin
                if (!expire) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (extend) begin
                    rty_d = rty_q + RTY_W'(1);
                end else begin
                    shad2_d = sync;
                    state_d = COMMIT;
                    err_d   = err_q | unstable;
                end
            end
            COMMIT: begin
                obs1_d  = shad1_q;
                obs2_d  = shad2_q;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                serr_d  = err_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign sel        = sel_q;
    assign busy       = busy_q;
    assign snap_valid = valid_q;
    assign snap_err   = serr_q;
    assign obs1_pos   = obs1_q.pos;
    assign obs1_type  = obs1_q.kind;
    assign obs2_pos   = obs2_q.pos;
    assign obs2_type  = obs2_q.kind;

endmodule

// File: tb/tb_obstacle_bus_reader.sv
// Scoreboard bench for obstacle_bus_reader: a cycle-level reference predicts every snapshot,
// and a monitor checks sel/busy/snap_valid/obs outputs after each rising edge.
module tb_obstacle_bus_reader;

    localparam int W    = 4;   // SETTLE(2) + 2 synchronizer cycles
    localparam int MAXR = 4;

    typedef struct {
        logic [8:0] p1;
        logic [2:0] t1;
        logic [8:0] p2;
        logic [2:0] t2;
        logic       err;
        logic       mask0;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_start;
    logic [7:0] bus_lo;
    logic [3:0] bus_hi;
    logic       sel;
    logic [8:0] obs1_pos, obs2_pos;
    logic [2:0] obs1_type, obs2_type;
    logic       snap_valid, busy, snap_err;

    logic [8:0] v1p, v2p;
    logic [2:0] v1t, v2t;

    int   cyc = 0;
    int   e0 = -1000, cap1 = -1000, due_c = -1000, idle_from = 0;
    int   ext1 = 0;
    int   n_cmp = 0, n_bad = 0;
    exp_t sb_q[$];
    exp_t cur;
    logic [8:0] com_p1, com_p2, act_p1;
    logic [2:0] com_t1, com_t2;
    logic       com_err;
    logic       exp_valid;

    obstacle_bus_reader #(.SETTLE(2), .MAX_RETRY(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .bus_lo      (bus_lo),
        .bus_hi      (bus_hi),
        .sel         (sel),
        .obs1_pos    (obs1_pos),
        .obs1_type   (obs1_type),
        .obs2_pos    (obs2_pos),
        .obs2_type   (obs2_type),
        .snap_valid  (snap_valid),
        .busy        (busy),
        .snap_err    (snap_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Generator chip model: the bus shows whichever obstacle sel picks.
    assign bus_lo = sel ? v1p[7:0] : v2p[7:0];
    assign bus_hi = sel ? {v1t, v1p[8]} : {v2t, v2p[8]};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: a request is taken only if the previous capture has finished;
    // the snapshot is whatever each obstacle shows when it is selected.
    task automatic drive(input logic fs);
        exp_t e;
        frame_start = fs;
        if (fs && rst_n && (cyc + 1 >= idle_from)) begin
            e0        = cyc + 1;
            cap1      = e0 + W + ext1;
            due_c     = cap1 + W + 1;
            idle_from = due_c + 1;
            e.p1 = v1p; e.t1 = v1t; e.p2 = v2p; e.t2 = v2t;
            e.err   = (ext1 >= MAXR);
            e.mask0 = (ext1 != 0);
            e.due   = due_c;
            sb_q.push_back(e);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        drive(1'b0);
    endtask

    task automatic pulse();
        @(negedge clk);
        drive(1'b1);
    endtask

    task automatic wait_idle();
        while (cyc + 1 < idle_from) tick();
        tick();
    endtask

    task automatic rand_vals();
        v1p = 9'($urandom); v1t = 3'($urandom);
        v2p = 9'($urandom); v2t = 3'($urandom);
    endtask

    // Monitor: compare every output shortly after each rising edge.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            sb_q.delete();
            com_p1 = '0; com_t1 = '0; com_p2 = '0; com_t2 = '0; com_err = 1'b0;
        end
        if (sb_q.size() != 0 && cyc > sb_q[0].due) begin
            chk("snap_missing", 32'(cyc), 32'(sb_q[0].due));
            void'(sb_q.pop_front());
        end
        exp_valid = (sb_q.size() != 0) && (sb_q[0].due == cyc);
        chk("snap_valid", 32'(snap_valid), 32'(exp_valid));
        if (exp_valid) begin
            cur    = sb_q.pop_front();
            com_p1 = cur.mask0 ? {cur.p1[8:1], obs1_pos[0]} : cur.p1;
            com_t1 = cur.t1; com_p2 = cur.p2; com_t2 = cur.t2; com_err = cur.err;
        end
        act_p1 = obs1_pos;
        chk("obs1_pos", 32'(act_p1), 32'(com_p1));
        chk("obs1_type", 32'(obs1_type), 32'(com_t1));
        chk("obs2_pos", 32'(obs2_pos), 32'(com_p2));
        chk("obs2_type", 32'(obs2_type), 32'(com_t2));
        chk("snap_err", 32'(snap_err), 32'(com_err));
        chk("sel", 32'(sel), 32'((cyc >= e0) && (cyc < cap1)));
        chk("busy", 32'(busy), 32'((cyc >= e0) && (cyc < due_c)));
    end

    initial begin
        rst_n = 1'b0;
        frame_start = 1'b0;
        rand_vals();
        repeat (3) tick();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0);
        repeat (50) tick();

        // Basic capture with fixed values.
        v1p = 9'h1A5; v1t = 3'd3; v2p = 9'h042; v2t = 3'd5;
        pulse();
        wait_idle();

        // Second request while busy is dropped; one in the snap_valid cycle is taken.
        rand_vals();
        pulse();
        tick(); tick();
        pulse();
        while (cyc < due_c) tick();
        pulse();
        wait_idle();

        // Obstacle 1 changes on the bus during PH2 after it was captured.
        rand_vals();
        pulse();
        while (cyc < e0 + W + 2) tick();
        v1p = 9'($urandom); v1t = 3'($urandom);
        wait_idle();

        // Reset in the middle of a capture.
        rand_vals();
        pulse();
        while (cyc < e0 + 4) tick();
        @(negedge clk);
        rst_n = 1'b0;
        e0 = -1000; cap1 = -1000; due_c = -1000; idle_from = 0;
        drive(1'b0);
        tick(); tick();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0);
        tick();
        rand_vals();
        pulse();
        wait_idle();

`ifdef OBSTACLE_READER_STABLE_EN
        // Obstacle 1 toggles every cycle while selected: all retries are used up.
        ext1 = MAXR;
        rand_vals();
        pulse();
        ext1 = 0;
        while (cyc < cap1) begin
            @(negedge clk);
            v1p[0] = ~v1p[0];
            drive(1'b0);
        end
        wait_idle();
`endif

        // Random requests, including many that arrive while busy.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (cyc + 1 >= idle_from && $urandom_range(0, 1) == 0) rand_vals();
            drive($urandom_range(0, 3) == 0);
        end
        repeat (15) tick();
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
